// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring divide.
// One bit per cycle, with a fixed latency of DATA_WIDTH+1 cycles from accept to the done pulse.
module mul_div_unit #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [DATA_WIDTH-1:0]     operandA,
  input  logic [DATA_WIDTH-1:0]     operandB,
  input  logic [REG_ADDR_WIDTH-1:0] destReg,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [REG_ADDR_WIDTH-1:0] resultReg,
  output logic                      regWrite
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state;
  state_t                    stateNext;
  logic [1:0]                opReg;
  logic [DATA_WIDTH-1:0]     multiplicand;
  logic [DATA_WIDTH-1:0]     divisor;
  logic [DATA_WIDTH-1:0]     quotient;
  logic [DATA_WIDTH:0]       remainder;
  logic [2*DATA_WIDTH-1:0]   product;
  logic [CNT_WIDTH-1:0]      counter;
  logic [REG_ADDR_WIDTH-1:0] destLatched;

  logic                      lastIter;
  logic [DATA_WIDTH:0]       addSum;
  logic [2*DATA_WIDTH-1:0]   productNext;
  logic [DATA_WIDTH:0]       remShift;
  logic [DATA_WIDTH:0]       diff;
  logic [DATA_WIDTH:0]       remainderNext;
  logic [DATA_WIDTH-1:0]     quotientNext;
  logic [DATA_WIDTH-1:0]     resultNext;

  assign lastIter = (counter == CNT_WIDTH'(DATA_WIDTH - 1));

  // Shift-add step: the carry out of the upper-half add lands in the product MSB after the shift
  always_comb begin
    addSum = {1'b0, product[2*DATA_WIDTH-1:DATA_WIDTH]};
    if (product[0]) begin
      addSum = addSum + {1'b0, multiplicand};
    end
    productNext = {addSum, product[DATA_WIDTH-1:1]};
  end

  // Restoring divide step; a zero divisor naturally yields all-ones quotient and remainder = dividend
  always_comb begin
    remShift      = {remainder[DATA_WIDTH-1:0], quotient[DATA_WIDTH-1]};
    diff          = remShift - {1'b0, divisor};
    remainderNext = diff[DATA_WIDTH] ? remShift : diff;
    quotientNext  = {quotient[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
  end

  always_comb begin
    unique case (opReg)
      OP_MUL:   resultNext = productNext[DATA_WIDTH-1:0];
      OP_MULHU: resultNext = productNext[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIVU:  resultNext = quotientNext;
      default:  resultNext = remainderNext[DATA_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = CALC;
      CALC:    if (lastIter) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath registers; operands are captured only on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opReg        <= '0;
      multiplicand <= '0;
      divisor      <= '0;
      quotient     <= '0;
      remainder    <= '0;
      product      <= '0;
      counter      <= '0;
      destLatched  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            opReg        <= op;
            multiplicand <= operandA;
            divisor      <= operandB;
            quotient     <= operandA;
            remainder    <= '0;
            product      <= {{DATA_WIDTH{1'b0}}, operandB};
            counter      <= '0;
            destLatched  <= destReg;
          end
        end
        CALC: begin
          product   <= productNext;
          remainder <= remainderNext;
          quotient  <= quotientNext;
          counter   <= counter + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered status outputs follow the next state so they align with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      regWrite  <= 1'b0;
      result    <= '0;
      resultReg <= '0;
    end else begin
      busy     <= (stateNext != IDLE);
      done     <= (stateNext == DONE);
      regWrite <= (stateNext == DONE);
      if (state == CALC && lastIter) begin
        result    <= resultNext;
        resultReg <= destLatched;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, hand-written corner sequences
// and random operations compared against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] operandA;
  logic [DW-1:0] operandB;
  logic [AW-1:0] destReg;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic [AW-1:0] resultReg;
  logic          regWrite;

  int checks;
  int errors;

  mul_div_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB), .destReg(destReg),
    .busy(busy), .done(done), .result(result),
    .resultReg(resultReg), .regWrite(regWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] dest;
    logic [DW-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain wide arithmetic
  function automatic logic [DW-1:0] model(input logic [1:0] o, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    case (o)
      2'b00:   return p[DW-1:0];
      2'b01:   return p[2*DW-1:DW];
      2'b10:   return (b == '0) ? {DW{1'b1}} : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  // Called right after a negedge with the DUT idle; returns at the negedge after E65.
  // injectAt>0 pulses a competing start request in that CALC cycle.
  task automatic runOp(input string name, input logic [1:0] o, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [AW-1:0] d,
                       input logic [DW-1:0] exp, input int injectAt);
    int earlyDone;
    int notBusy;
    start = 1'b1; op = o; operandA = a; operandB = b; destReg = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    operandA = {$urandom, $urandom}; operandB = {$urandom, $urandom};
    destReg = AW'($urandom); op = 2'($urandom);
    check({name, " busy after accept"}, DW'(busy), DW'(1));
    earlyDone = (done || regWrite) ? 1 : 0;
    notBusy = 0;
    for (int i = 1; i < 64; i++) begin
      if (i == injectAt) begin
        start = 1'b1; op = 2'b10; operandA = 100; operandB = 7; destReg = 9;
      end
      @(negedge clk);
      start = 1'b0;
      if (done || regWrite) earlyDone++;
      if (!busy) notBusy++;
    end
    check({name, " early done count"}, DW'(earlyDone), DW'(0));
    check({name, " busy during calc"}, DW'(notBusy), DW'(0));
    @(negedge clk);
    check({name, " done"}, DW'({busy, done, regWrite}), DW'(3'b111));
    check({name, " result"}, result, exp);
    check({name, " resultReg"}, DW'(resultReg), DW'(d));
    @(negedge clk);
    check({name, " idle after"}, DW'({busy, done, regWrite}), DW'(3'b000));
  endtask

  vec_t vecs[$];

  initial begin
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [1:0]    ro;
    logic [AW-1:0] rd;
    int            strayDone;
    checks = 0; errors = 0;
    start = 0; op = 0; operandA = 0; operandB = 0; destReg = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset outputs", DW'({busy, done, regWrite}), DW'(0));
    check("reset result", result, '0);
    check("reset resultReg", DW'(resultReg), '0);
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back('{2'b00, 64'd3, 64'd5, 5'd7, 64'd15});
    vecs.push_back('{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'd1});
    vecs.push_back('{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{2'b10, 64'd100, 64'd7, 5'd4, 64'd14});
    vecs.push_back('{2'b11, 64'd100, 64'd7, 5'd5, 64'd2});
    vecs.push_back('{2'b10, 64'h1234, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{2'b11, 64'h1234, 64'd0, 5'd0, 64'h1234});
    vecs.push_back('{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31,
                     64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{2'b10, 64'd5, 64'd9, 5'd8, 64'd0});
    foreach (vecs[i])
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest,
            vecs[i].exp, 0);

    // Competing start mid-CALC is ignored; next op launches on the first IDLE edge
    runOp("ignore start", 2'b00, 64'd6, 64'd7, 5'd3, 64'd42, 20);
    runOp("back to back", 2'b11, 64'd50, 64'd8, 5'd9, 64'd2, 0);

    // Async reset in the middle of a DIVU
    start = 1'b1; op = 2'b10; operandA = 64'd1000; operandB = 64'd3; destReg = 5'd12;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset clears", DW'({busy, done, regWrite}), DW'(0));
    @(negedge clk);
    rst = 1'b0;
    strayDone = 0;
    repeat (80) begin
      @(negedge clk);
      if (done || regWrite || busy) strayDone++;
    end
    check("no done after abort", DW'(strayDone), DW'(0));
    runOp("after reset", 2'b00, 64'd2, 64'd2, 5'd10, 64'd4, 0);

    // Random operations against the model
    for (int n = 0; n < 24; n++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = DW'($urandom_range(1, 255));
        2:       rb = DW'($urandom);
        default: rb = {$urandom, $urandom};
      endcase
      if (n % 5 == 0) ra = DW'($urandom_range(0, 1000));
      ro = 2'($urandom);
      rd = AW'($urandom);
      runOp($sformatf("rand%0d op%0d", n, ro), ro, ra, rb, rd, model(ro, ra, rb), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 64-bit unsigned multiply/divide execute unit.
- Sits directly downstream of the register bank: consumes the two registered read operands and a destination register index.
- Produces a result and a write-enable/address pair that feed the register bank write port (writeData, writeReg, regWrite).
- Replaces a large combinational multiplier/divider with a fixed-latency, one-bit-per-cycle datapath.

Parameters:
- DATA_WIDTH, 64, operand/result width in bits.
- REG_ADDR_WIDTH, 5, destination register index width.
- CNT_WIDTH, 7, iteration counter width; must hold the value DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  00 MUL (low half of product), 01 MULHU (high half), 10 DIVU (quotient), 11 REMU (remainder).
- operandA  input  DATA_WIDTH  multiplicand / dividend.
- operandB  input  DATA_WIDTH  multiplier / divisor.
- destReg  input  REG_ADDR_WIDTH  destination register index.
- busy  output  1  high from the accepting edge until return to IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  DATA_WIDTH  operation result; valid while done=1.
- resultReg  output  REG_ADDR_WIDTH  latched destReg; valid while done=1.
- regWrite  output  1  register bank write enable; equals done.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, regWrite=0, result=0, resultReg=0, counter=0, internal accumulators=0. No write is issued for an aborted operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge E0: latch op, operandA, operandB and destReg; clear the accumulators; counter=0; go to CALC; busy=1 from E0.
  - start=0: remain in IDLE.
- CALC: one iteration per edge, counter increments each edge. On the edge where counter reaches DATA_WIDTH (E64 with defaults), go to DONE.
- DONE:
  - done=1, regWrite=1, result and resultReg driven for exactly one cycle.
  - Next edge (E65): go to IDLE; busy=0, done=0, regWrite=0.
- Latency: done is high in the cycle following edge E64. Fixed for all ops and operand values; no early termination.
- start while busy=1 (CALC or DONE): ignored, no queueing. Operand and destReg changes after E0 have no effect.
- Next operation: may start at the first IDLE edge (E65), giving a throughput of 1 operation per 66 cycles.
- Multiply: shift-add, 2*DATA_WIDTH product register, all unsigned.
  - Each iteration: if multiplier LSB=1, add the multiplicand to the upper half; then shift the whole product right by 1, keeping the carry.
  - MUL returns product[63:0]; MULHU returns product[127:64].
- Divide: restoring, unsigned.
  - Remainder register is DATA_WIDTH+1 bits.
  - Each iteration: shift {remainder, quotient} left by 1, subtract the divisor, and restore if the result is negative; the quotient bit is the inverted sign.
  - DIVU returns the quotient; REMU returns the remainder's low DATA_WIDTH bits.
- Divide by zero (operandB=0): DIVU result = all ones; REMU result = operandA. Same fixed latency; not signalled as an error.
- result and resultReg hold their last value after done falls; consumers must qualify with regWrite.
- destReg=0 is written like any other index; the register bank owns any zero-register policy.

Test Plan:
- Reset, then MUL with A=3, B=5, destReg=7, start pulse at E0 -> busy=1 from E0; done=regWrite=1 only in the cycle after E64; result=15, resultReg=7; busy=0 after E65.
- MULHU with A=0xFFFF_FFFF_FFFF_FFFF, B=2 -> result=0x1; the same operands with MUL -> result=0xFFFF_FFFF_FFFF_FFFE.
- DIVU with A=100, B=7 -> result=14; REMU with the same operands -> result=2; both complete at the same latency.
- DIVU with A=0x1234, B=0 -> result=0xFFFF_FFFF_FFFF_FFFF; REMU with A=0x1234, B=0 -> result=0x1234.
- start a MUL 6*7 (destReg=3), then assert start again mid-CALC with different operands and destReg=9 -> second request ignored; exactly one done with result=42, resultReg=3. A new start at the first IDLE edge is accepted.
- Assert rst at cycle 30 of a DIVU -> busy, done and regWrite go 0 immediately, asynchronously; no done pulse follows. A subsequent MUL 2*2 completes normally with result=4.
